gemm_pass_seq: RTL and testbench

Compute sequencer for the GEMM core. It sits between the source buffer load (`batch_ctrl`) and the output drain (`out_ctrl`). When a source batch is complete, it runs `N_PASS` accumulation passes. Each pass streams `K_LEN` read addresses into the source and parameter buffers, brackets the pass with `k_init`/`k_fin`, and holds `k_fin` off while the output drain is busy. After the last pass's output has drained, it pulses `s_fin` to start the destination stream.

---
 rtl/gemm_pass_seq.sv | 145 ++++++++++++++
 tb/tb_gemm_pass_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_pass_seq.sv
`default_nettype none
// ============================================================================
// Module   : gemm_pass_seq
// Brief    : GEMM compute sequencer. Runs N_PASS accumulation passes of K_LEN
//            steps per loaded source batch, then signals batch completion.
// Option   : GEMM_PASS_SEQ_OVERLAP_EN - next pass starts while previous drains
// Revision : 1.0 - initial release
// ============================================================================
module gemm_pass_seq #(
    parameter int K_LEN  = 32,
    parameter int N_PASS = 4,
    parameter int LAT    = 2
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          run,
    input  logic                                          s_init,
    input  logic                                          out_busy,
    output logic                                          exec,
    output logic [$clog2(K_LEN)-1:0]                      ka,
    output logic [((N_PASS > 1) ? $clog2(N_PASS) : 1)-1:0] pa,
    output logic                                          k_init,
    output logic                                          k_fin,
    output logic                                          s_fin,
    output logic                                          busy
);

    localparam int KA_W = $clog2(K_LEN);
    localparam int PA_W = (N_PASS > 1) ? $clog2(N_PASS) : 1;
    localparam int FC_W = $clog2(LAT + 1);

    localparam logic [KA_W-1:0] KA_LAST = KA_W'(K_LEN - 1);
    localparam logic [PA_W-1:0] PA_LAST = PA_W'(N_PASS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state;
    logic [FC_W-1:0]   fcnt;

    // fcnt holds the cycles still needed before the accumulator result is
    // valid; k_fin is registered, so it is armed one cycle before fcnt hits 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            fcnt   <= '0;
            ka     <= '0;
            pa     <= '0;
            exec   <= 1'b0;
            k_init <= 1'b0;
            k_fin  <= 1'b0;
            s_fin  <= 1'b0;
            busy   <= 1'b0;
        end else if (!run) begin
            state  <= ST_IDLE;
            fcnt   <= '0;
            ka     <= '0;
            pa     <= '0;
            exec   <= 1'b0;
            k_init <= 1'b0;
            k_fin  <= 1'b0;
            s_fin  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            exec   <= 1'b0;
            k_init <= 1'b0;
            k_fin  <= 1'b0;
            s_fin  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s_init) begin
                        pa   <= '0;
                        ka   <= '0;
                        busy <= 1'b1;
`ifdef GEMM_PASS_SEQ_OVERLAP_EN
                        state  <= ST_RUN;
                        exec   <= 1'b1;
                        k_init <= 1'b1;
`else
                        state  <= ST_WAIT;
`endif
                    end
                end
                ST_WAIT: begin
                    if (!out_busy) begin
                        state  <= ST_RUN;
                        ka     <= '0;
                        exec   <= 1'b1;
                        k_init <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ka == KA_LAST) begin
                        state <= ST_FLUSH;
                        fcnt  <= FC_W'(LAT - 1);
                        k_fin <= (LAT == 1) && !out_busy;
                    end else begin
                        ka   <= ka + KA_W'(1);
                        exec <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (k_fin) begin
                        if (pa == PA_LAST) begin
                            state <= ST_DONE;
                        end else begin
                            pa <= pa + PA_W'(1);
`ifdef GEMM_PASS_SEQ_OVERLAP_EN
                            state  <= ST_RUN;
                            ka     <= '0;
                            exec   <= 1'b1;
                            k_init <= 1'b1;
`else
                            state  <= ST_WAIT;
`endif
                        end
                    end else begin
                        if (fcnt != '0) begin
                            fcnt <= fcnt - FC_W'(1);
                        end
                        k_fin <= ((fcnt == '0) || (fcnt == FC_W'(1))) && !out_busy;
                    end
                end
                ST_DONE: begin
                    if (!out_busy) begin
                        state <= ST_IDLE;
                        s_fin <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gemm_pass_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_gemm_pass_seq
// Brief    : Self-checking bench for gemm_pass_seq (defaults K=32, N=4, LAT=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gemm_pass_seq;

    localparam int K_LEN  = 32;
    localparam int N_PASS = 4;
    localparam int LAT    = 2;
`ifdef GEMM_PASS_SEQ_OVERLAP_EN
    localparam int FIRST    = 1;
    localparam int PER      = 34;
    localparam int GAP_BUSY = 34;
`else
    localparam int FIRST    = 2;
    localparam int PER      = 35;
    localparam int GAP_BUSY = 39;
`endif
    localparam int SF_N = FIRST + 3 * PER + 35;

    logic       clk = 1'b0;
    logic       reset, run, s_init, out_busy;
    logic       exec, k_init, k_fin, s_fin, busy;
    logic [4:0] ka;
    logic [1:0] pa;

    always #5 clk = ~clk;

    gemm_pass_seq #(.K_LEN(K_LEN), .N_PASS(N_PASS), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .run(run), .s_init(s_init), .out_busy(out_busy),
        .exec(exec), .ka(ka), .pa(pa), .k_init(k_init), .k_fin(k_fin),
        .s_fin(s_fin), .busy(busy)
    );

    typedef struct packed {
        logic       exec;
        logic       k_init;
        logic       k_fin;
        logic       s_fin;
        logic       busy;
        logic [4:0] ka;
        logic [1:0] pa;
    } snap_t;

    typedef struct {
        int n; int exec; int ka; int pa; int k_init; int k_fin; int s_fin; int busy;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    snap_t tr [0:159];
    vec_t  tbl [$];

    function automatic snap_t snap();
        snap_t s;
        s.exec = exec; s.k_init = k_init; s.k_fin = k_fin; s.s_fin = s_fin;
        s.busy = busy; s.ka = ka; s.pa = pa;
        return s;
    endfunction

    function automatic logic [31:0] pk(int ex, int ki, int kf, int sf, int bz, int kav, int pav);
        return {20'd0, 1'(ex), 1'(ki), 1'(kf), 1'(sf), 1'(bz), 5'(kav), 2'(pav)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cleanup();
        run = 1'b0; out_busy = 1'b0; s_init = 1'b0;
        step();
        run = 1'b1;
        step();
    endtask

    initial begin
        int    hit, kf_n, sf_n, busy_left, clash, quiet_bad, stray, lst;
        int    kf_q [$];
        int    st_q [$];
        snap_t s;

        reset = 1'b1; run = 1'b1; s_init = 1'b0; out_busy = 1'b0;
        step(); step(); step();
        chk("reset_state", 32'(snap()), 32'd0);
        reset = 1'b0;
        step();
        chk("idle_after_reset", 32'(snap()), 32'd0);

        // ---------------- Scenario 1: free-running batch, out_busy = 0
`ifdef GEMM_PASS_SEQ_OVERLAP_EN
        tbl.push_back('{0,   0, -1, -1, 0, 0, 0, 0});
        tbl.push_back('{1,   1,  0,  0, 1, 0, 0, 1});
        tbl.push_back('{32,  1, 31,  0, 0, 0, 0, 1});
        tbl.push_back('{33,  0, 31,  0, 0, 0, 0, 1});
        tbl.push_back('{34,  0, -1,  0, 0, 1, 0, 1});
        tbl.push_back('{35,  1,  0,  1, 1, 0, 0, 1});
        tbl.push_back('{69,  1,  0,  2, 1, 0, 0, 1});
        tbl.push_back('{103, 1,  0,  3, 1, 0, 0, 1});
        tbl.push_back('{134, 1, 31,  3, 0, 0, 0, 1});
        tbl.push_back('{136, 0, -1,  3, 0, 1, 0, 1});
        tbl.push_back('{137, 0, -1,  3, 0, 0, 0, 1});
        tbl.push_back('{138, 0, -1, -1, 0, 0, 1, 0});
        tbl.push_back('{139, 0, -1, -1, 0, 0, 0, 0});
`else
        tbl.push_back('{0,   0, -1, -1, 0, 0, 0, 0});
        tbl.push_back('{1,   0, -1,  0, 0, 0, 0, 1});
        tbl.push_back('{2,   1,  0,  0, 1, 0, 0, 1});
        tbl.push_back('{33,  1, 31,  0, 0, 0, 0, 1});
        tbl.push_back('{34,  0, 31,  0, 0, 0, 0, 1});
        tbl.push_back('{35,  0, -1,  0, 0, 1, 0, 1});
        tbl.push_back('{36,  0, -1,  1, 0, 0, 0, 1});
        tbl.push_back('{37,  1,  0,  1, 1, 0, 0, 1});
        tbl.push_back('{72,  1,  0,  2, 1, 0, 0, 1});
        tbl.push_back('{107, 1,  0,  3, 1, 0, 0, 1});
        tbl.push_back('{138, 1, 31,  3, 0, 0, 0, 1});
        tbl.push_back('{140, 0, -1,  3, 0, 1, 0, 1});
        tbl.push_back('{141, 0, -1,  3, 0, 0, 0, 1});
        tbl.push_back('{142, 0, -1, -1, 0, 0, 1, 0});
        tbl.push_back('{143, 0, -1, -1, 0, 0, 0, 0});
`endif
        s_init = 1'b1;
        tr[0] = snap();
        for (int n = 1; n < 160; n++) begin
            step();
            s_init = 1'b0;
            tr[n] = snap();
        end
        foreach (tbl[i]) begin
            s = tr[tbl[i].n];
            chk($sformatf("vec n=%0d", tbl[i].n),
                pk(s.exec, s.k_init, s.k_fin, s.s_fin, s.busy,
                   (tbl[i].ka >= 0) ? int'(s.ka) : 0, (tbl[i].pa >= 0) ? int'(s.pa) : 0),
                pk(tbl[i].exec, tbl[i].k_init, tbl[i].k_fin, tbl[i].s_fin, tbl[i].busy,
                   (tbl[i].ka >= 0) ? tbl[i].ka : 0, (tbl[i].pa >= 0) ? tbl[i].pa : 0));
        end
        // Timing model: pass p occupies PER cycles starting at FIRST + p*PER.
        for (int n = 0; n < 160; n++) begin
            int p, o, ex, kf;
            p = 0; o = 0;
            if (n >= FIRST) begin p = (n - FIRST) / PER; o = (n - FIRST) % PER; end
            ex = (n >= FIRST && p < 4 && o < 32) ? 1 : 0;
            kf = (n >= FIRST && p < 4 && o == 33) ? 1 : 0;
            s  = tr[n];
            chk($sformatf("trace n=%0d", n),
                pk(s.exec, s.k_init, s.k_fin, s.s_fin, s.busy,
                   ex ? int'(s.ka) : 0, ex ? int'(s.pa) : 0),
                pk(ex, (ex != 0 && o == 0) ? 1 : 0, kf, (n == SF_N) ? 1 : 0,
                   (n >= 1 && n < SF_N) ? 1 : 0, ex ? o : 0, ex ? p : 0));
        end

        // ---------------- Scenario 2: out_busy modelled as the output drain
        cleanup();
        s_init = 1'b1; step(); s_init = 1'b0;
        busy_left = 0; clash = 0; sf_n = -1;
        for (int n = 1; n <= 220; n++) begin
            if (n > 1) step();
            out_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            if ((k_fin || s_fin) && out_busy) clash++;
            if (k_fin) begin kf_q.push_back(n); busy_left = 4; end
            if (exec && ka == 5'd0) st_q.push_back(n);
            if (s_fin && sf_n < 0) sf_n = n;
        end
        out_busy = 1'b0;
        chk("drain k_fin count", 32'(kf_q.size()), 32'd4);
        chk("drain pass count", 32'(st_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain k_fin[%0d] cycle", i),
                (i < kf_q.size()) ? 32'(kf_q[i]) : 32'hFFFF_FFFF, 32'(FIRST + 33 + GAP_BUSY * i));
            chk($sformatf("drain exec start[%0d] cycle", i),
                (i < st_q.size()) ? 32'(st_q[i]) : 32'hFFFF_FFFF, 32'(FIRST + GAP_BUSY * i));
        end
        lst = FIRST + 33 + GAP_BUSY * 3;
        chk("drain s_fin cycle", 32'(sf_n), 32'(lst + 6));
        chk("pulse while out_busy", 32'(clash), 32'd0);

        // ---------------- Scenario 3: out_busy held across end of FLUSH
        cleanup();
        s_init = 1'b1; step(); s_init = 1'b0;
        lst = FIRST + 31; quiet_bad = 0; kf_n = -1;
        for (int n = 1; n <= lst + 14; n++) begin
            if (n > 1) step();
            out_busy = (n >= lst + 1 && n <= lst + 10);
            if (n >= lst + 1 && n <= lst + 11 && (exec || k_fin)) quiet_bad++;
            if (k_fin && kf_n < 0) kf_n = n;
        end
        out_busy = 1'b0;
        chk("hold quiet", 32'(quiet_bad), 32'd0);
        chk("held k_fin cycle", 32'(kf_n), 32'(lst + 12));

        // ---------------- Scenario 4: abort at ka=17 in pass 2
        cleanup();
        s_init = 1'b1; step(); s_init = 1'b0;
        hit = -1;
        for (int n = 1; n <= 200; n++) begin
            if (n > 1) step();
            if (exec && ka == 5'd17 && pa == 2'd2) begin hit = n; break; end
        end
        chk("abort point cycle", 32'(hit), 32'(FIRST + 2 * PER + 17));
        run = 1'b0;
        step();
        chk("abort outputs", 32'(snap()), 32'd0);
        run = 1'b1;
        stray = 0;
        for (int n = 0; n < 150; n++) begin
            step();
            if (k_fin || s_fin || exec || busy) stray++;
        end
        chk("no activity after abort", 32'(stray), 32'd0);
        s_init = 1'b1; step(); s_init = 1'b0;
        for (int n = 2; n <= FIRST; n++) step();
        chk("restart first exec", pk(exec, k_init, 0, 0, 0, int'(ka), int'(pa)), pk(1, 1, 0, 0, 0, 0, 0));

        // ---------------- Scenario 5: async reset mid-RUN, s_init ignored in RUN
        cleanup();
        s_init = 1'b1; step(); s_init = 1'b0;
        hit = -1;
        for (int n = 1; n <= 60; n++) begin
            if (n > 1) step();
            if (exec && ka == 5'd5) begin hit = n; break; end
        end
        chk("pre-reset ka=5 cycle", 32'(hit), 32'(FIRST + 5));
        #2 reset = 1'b1;
        #1;
        chk("async reset outputs", 32'(snap()), 32'd0);
        step(); step();
        reset = 1'b0;
        chk("outputs after reset release", 32'(snap()), 32'd0);
        s_init = 1'b1; step(); s_init = 1'b0;
        kf_n = -1;
        for (int n = 1; n <= FIRST + 40; n++) begin
            if (n > 1) step();
            s_init = (n == FIRST + 10);
            if (n == FIRST + 11)
                chk("run continues past s_init", pk(exec, 0, 0, 0, 0, int'(ka), int'(pa)),
                    pk(1, 0, 0, 0, 0, 11, 0));
            if (k_fin && kf_n < 0) kf_n = n;
        end
        s_init = 1'b0;
        chk("k_fin after ignored s_init", 32'(kf_n), 32'(FIRST + 33));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
